// File: rtl/demux_l2.sv
// ============================================================================
// demux_l2 -- byte-stream to 4-lane frame demultiplexer
//
// A free-running 2-bit slot pointer assigns each cycle of the incoming byte
// stream to one lane. Lanes 0..LANES-2 are parked in staging registers. In the
// last slot the staged lanes and the live last-lane byte go to the outputs
// together, so a frame is only ever presented whole. Invalid slots carry
// 8'h00 as their data.
//
// Optional feature (compile-time macro DEMUX_IDLE_EN):
//   defined   -> a 2-bit saturating counter tracks consecutive all-invalid
//                frames; idle_out rises when the second one is presented
//                and falls when a frame with any valid lane is presented.
//   undefined -> idle_out is tied to 0 and there is no counter.
//
// Parameters:
//   LANES       byte lanes per frame (only 4 is supported)
// Ports:
//   clk_4f      single clock at the serial byte rate, rising edge
//   reset       synchronous active-high reset
//   data_000    time-multiplexed input byte, one lane slot per cycle
//   valid_000   qualifies data_000 in the current slot
//   data_0d..3d demultiplexed lane bytes (registered)
//   valid_0d..3d per-lane valid flags (registered)
//   frame_done  one-cycle pulse in the cycle after a frame is presented
//   idle_out    link-idle indication
// ============================================================================
module demux_l2 #(
    parameter int LANES = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_000,
    input  logic       valid_000,
    output logic [7:0] data_0d,
    output logic [7:0] data_1d,
    output logic [7:0] data_2d,
    output logic [7:0] data_3d,
    output logic       valid_0d,
    output logic       valid_1d,
    output logic       valid_2d,
    output logic       valid_3d,
    output logic       frame_done,
    output logic       idle_out
);

    logic [1:0]       slot_q;
    logic [7:0]       stg_data_q  [LANES-1];
    logic [LANES-2:0] stg_valid_q;
    logic [7:0]       out_data_q  [LANES];
    logic [LANES-1:0] out_valid_q;
    logic             frame_done_q;

    logic [7:0]       byte_in;
    logic             last_slot;
    logic             all_invalid;

    // Invalid slots are stored as zero so stale bytes never leak to outputs.
    assign byte_in     = valid_000 ? data_000 : 8'h00;
    assign last_slot   = (slot_q == 2'(LANES - 1));
    assign all_invalid = ~|{valid_000, stg_valid_q};

    // Slot pointer runs regardless of valid_000: there is no backpressure.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            slot_q       <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_q + 2'd1;
            frame_done_q <= last_slot;
        end
    end

    genvar gi;

    // Staging for every lane except the last, which is taken live.
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_stage
            always_ff @(posedge clk_4f) begin
                if (reset) begin
                    stg_data_q[gi]  <= 8'h00;
                    stg_valid_q[gi] <= 1'b0;
                end else if (slot_q == 2'(gi)) begin
                    stg_data_q[gi]  <= byte_in;
                    stg_valid_q[gi] <= valid_000;
                end
            end
        end
    endgenerate

    // All output lanes update together on the last-slot edge.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_out
            always_ff @(posedge clk_4f) begin
                if (reset) begin
                    out_data_q[gi]  <= 8'h00;
                    out_valid_q[gi] <= 1'b0;
                end else if (last_slot) begin
                    if (gi < LANES - 1) begin
                        out_data_q[gi]  <= stg_data_q[gi];
                        out_valid_q[gi] <= stg_valid_q[gi];
                    end else begin
                        out_data_q[gi]  <= byte_in;
                        out_valid_q[gi] <= valid_000;
                    end
                end
            end
        end
    endgenerate

`ifdef DEMUX_IDLE_EN
    logic [1:0] idle_cnt_q;
    logic [1:0] idle_cnt_d;
    logic       idle_q;
    logic       idle_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        idle_d     = idle_q;
        if (last_slot) begin
            if (all_invalid) begin
                idle_cnt_d = (idle_cnt_q == 2'd3) ? 2'd3 : idle_cnt_q + 2'd1;
                // Second consecutive all-invalid frame or later.
                idle_d     = (idle_cnt_q != 2'd0);
            end else begin
                idle_cnt_d = 2'd0;
                idle_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            idle_cnt_q <= 2'd0;
            idle_q     <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign idle_out = idle_q;
`else
    logic unused_idle;
    assign unused_idle = all_invalid;
    assign idle_out    = 1'b0;
`endif

    assign data_0d    = out_data_q[0];
    assign data_1d    = out_data_q[1];
    assign data_2d    = out_data_q[2];
    assign data_3d    = out_data_q[3];
    assign valid_0d   = out_valid_q[0];
    assign valid_1d   = out_valid_q[1];
    assign valid_2d   = out_valid_q[2];
    assign valid_3d   = out_valid_q[3];
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_l2.sv
// ============================================================================
// tb_demux_l2 -- self-checking bench for demux_l2
//
// Frames are packed as 32-bit words with lane k at bits [8k+7:8k] and valid
// bit k for lane k. A fixed table covers the directed frames; random frames
// are checked against a frame-level model (masked bytes, consecutive-idle
// count). Every cycle is checked: outputs must hold and frame_done stay low
// for the first three slots, then the new frame appears with frame_done high.
// Build with +define+DEMUX_IDLE_EN for the idle-detection variant.
// ============================================================================
module tb_demux_l2;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] data_000;
    logic       valid_000;
    logic [7:0] data_0d, data_1d, data_2d, data_3d;
    logic       valid_0d, valid_1d, valid_2d, valid_3d;
    logic       frame_done;
    logic       idle_out;

    int tests = 0;
    int fails = 0;

    // Frame-level reference state
    logic [31:0] exp_d;
    logic [3:0]  exp_v;
    int          idle_run;
    logic        exp_idle;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
        logic [31:0] ed;
        logic [3:0]  ev;
    } vec_t;

    demux_l2 #(.LANES(4)) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .data_000   (data_000),
        .valid_000  (valid_000),
        .data_0d    (data_0d),
        .data_1d    (data_1d),
        .data_2d    (data_2d),
        .data_3d    (data_3d),
        .valid_0d   (valid_0d),
        .valid_1d   (valid_1d),
        .valid_2d   (valid_2d),
        .valid_3d   (valid_3d),
        .frame_done (frame_done),
        .idle_out   (idle_out)
    );

    always #5 clk_4f = ~clk_4f;

    function automatic logic [31:0] out_d();
        return {data_3d, data_2d, data_1d, data_0d};
    endfunction

    function automatic logic [3:0] out_v();
        return {valid_3d, valid_2d, valid_1d, valid_0d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    // Model: a presented frame updates the outputs and the idle run length.
    task automatic model_present(input logic [31:0] ed, input logic [3:0] ev);
        exp_d = ed;
        exp_v = ev;
        if (ev == 4'b0000) idle_run = idle_run + 1;
        else               idle_run = 0;
`ifdef DEMUX_IDLE_EN
        exp_idle = (idle_run >= 2);
`else
        exp_idle = 1'b0;
`endif
    endtask

    task automatic model_reset();
        exp_d    = 32'h0;
        exp_v    = 4'h0;
        idle_run = 0;
        exp_idle = 1'b0;
    endtask

    // Apply one slot; slot 3 presents the frame (ed/ev), others must hold.
    task automatic drive_slot(input int k, input logic [7:0] b, input logic v,
                              input logic [31:0] ed, input logic [3:0] ev,
                              input string tag);
        @(negedge clk_4f);
        reset     = 1'b0;
        data_000  = b;
        valid_000 = v;
        @(posedge clk_4f);
        #1;
        if (k < 3) begin
            chk({tag, " hold data"},  out_d(), exp_d);
            chk({tag, " hold valid"}, {28'h0, out_v()}, {28'h0, exp_v});
            chk({tag, " fd low"},     {31'h0, frame_done}, 32'h0);
            chk({tag, " idle hold"},  {31'h0, idle_out}, {31'h0, exp_idle});
        end else begin
            model_present(ed, ev);
            chk({tag, " data"},  out_d(), exp_d);
            chk({tag, " valid"}, {28'h0, out_v()}, {28'h0, exp_v});
            chk({tag, " fd"},    {31'h0, frame_done}, 32'h1);
            chk({tag, " idle"},  {31'h0, idle_out}, {31'h0, exp_idle});
            $display("[TB] frame %s: data=%08h valid=%04b fd=%0b idle=%0b",
                     tag, out_d(), out_v(), frame_done, idle_out);
        end
    endtask

    task automatic run_frame(input logic [31:0] d, input logic [3:0] v,
                             input logic [31:0] ed, input logic [3:0] ev,
                             input string tag);
        for (int k = 0; k < 4; k++)
            drive_slot(k, d[8*k +: 8], v[k], ed, ev, tag);
    endtask

    // One reset edge with garbage on the inputs; reset stays high until the
    // next slot is driven so the slot pointer starts at 0 there.
    task automatic do_reset(input string tag);
        @(negedge clk_4f);
        reset     = 1'b1;
        data_000  = 8'hEE;
        valid_000 = 1'b1;
        @(posedge clk_4f);
        #1;
        model_reset();
        chk({tag, " data"},  out_d(), 32'h0);
        chk({tag, " valid"}, {28'h0, out_v()}, 32'h0);
        chk({tag, " fd"},    {31'h0, frame_done}, 32'h0);
        chk({tag, " idle"},  {31'h0, idle_out}, 32'h0);
        $display("[TB] reset %s: data=%08h valid=%04b fd=%0b idle=%0b",
                 tag, out_d(), out_v(), frame_done, idle_out);
    endtask

    // Reference masking of a raw frame, straight from the lane rule.
    function automatic logic [31:0] mask_frame(input logic [31:0] d, input logic [3:0] v);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < 4; k++)
            if (v[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    vec_t vecs [6];

    initial begin
        reset     = 1'b1;
        data_000  = 8'h00;
        valid_000 = 1'b0;
        model_reset();

        vecs[0] = '{d: 32'hA3A2A1A0, v: 4'b1111, ed: 32'hA3A2A1A0, ev: 4'b1111};
        vecs[1] = '{d: 32'h44332211, v: 4'b0101, ed: 32'h00330011, ev: 4'b0101};
        vecs[2] = '{d: 32'hDEADBEEF, v: 4'b1000, ed: 32'hDE000000, ev: 4'b1000};
        vecs[3] = '{d: 32'hC3C2C1C0, v: 4'b1111, ed: 32'hC3C2C1C0, ev: 4'b1111};
        vecs[4] = '{d: 32'hD3D2D1D0, v: 4'b1111, ed: 32'hD3D2D1D0, ev: 4'b1111};
        vecs[5] = '{d: 32'hE3E2E1E0, v: 4'b1111, ed: 32'hE3E2E1E0, ev: 4'b1111};

        repeat (2) @(posedge clk_4f);
        do_reset("init");

        // Directed table: basic frame, masked lanes, then back-to-back frames
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].d, vecs[i].v, vecs[i].ed, vecs[i].ev, $sformatf("vec%0d", i));

        // Partial frame cut by reset must never appear
        drive_slot(0, 8'h90, 1'b1, 32'h0, 4'h0, "partial");
        drive_slot(1, 8'h91, 1'b1, 32'h0, 4'h0, "partial");
        do_reset("midframe");
        run_frame(32'h53525150, 4'b1111, 32'h53525150, 4'b1111, "post_reset");

        // Idle sequence: three all-invalid frames, then a valid one
        for (int i = 0; i < 3; i++)
            run_frame(32'h0F0E0D0C + i, 4'b0000, 32'h0, 4'b0000, $sformatf("idle%0d", i));
        run_frame(32'h77665544, 4'b0010, 32'h00005500, 4'b0010, "wake");

        // Random frames against the model, biased toward all-invalid frames
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            logic [3:0]  v;
            d = $urandom;
            v = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            if (i == 25) do_reset("rand_reset");
            run_frame(d, v, mask_frame(d, v), v, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_l2.md
DEMUX_L2 -- requirements
Module: demux_l2

Interface
REQ-001 The block SHALL have one parameter: LANES, default 4, meaning the number of byte lanes per frame; only the value 4 is supported.
REQ-002 The port clk_4f SHALL be an input, 1 bit wide: the single clock, equal to the serial byte rate; all logic is on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The port data_000 SHALL be an input, 8 bits wide: the time-multiplexed byte stream, one lane slot per cycle.
REQ-005 The port valid_000 SHALL be an input, 1 bit wide: qualifies data_000 in the current slot.
REQ-006 The ports data_0d, data_1d, data_2d and data_3d SHALL be outputs, 8 bits wide each: the demultiplexed lane bytes.
REQ-007 The ports valid_0d, valid_1d, valid_2d and valid_3d SHALL be outputs, 1 bit wide each: the per-lane valid flags.
REQ-008 The port frame_done SHALL be an output, 1 bit wide: a one-cycle pulse when a new frame is presented on the outputs.
REQ-009 The port idle_out SHALL be an output, 1 bit wide: the link-idle indication (see Configuration).

Function
REQ-010 A 2-bit slot pointer SHALL be 0 in the first cycle after reset deasserts and SHALL increment by 1 every cycle, wrapping 3->0, independent of valid_000.
REQ-011 In slot k, the block SHALL capture data_000 and valid_000 into staging register k.
REQ-012 When valid_000=0 in slot k, the block SHALL write 8'h00 into staging data k instead of data_000.
REQ-013 In slot 3, the block SHALL transfer staging lanes 0..2 plus the live slot-3 input to all outputs together on the same edge.
REQ-014 Outputs SHALL hold stable for exactly 4 cycles between updates.
REQ-015 Latency SHALL be 4 cycles for the lane-0 byte: sampled at edge n, visible after edge n+3.
REQ-016 Latency SHALL be 1 cycle for the lane-3 byte.
REQ-017 frame_done SHALL be high for exactly the one cycle following each output update edge, and 0 otherwise.
REQ-018 Partial frames SHALL never reach the outputs; lanes of a frame SHALL never mix with lanes of another frame.
REQ-019 The block SHALL have no backpressure: every slot is consumed.

Reset
REQ-020 While reset=1 at a clock edge, the block SHALL clear the slot pointer to 0, all staging registers to 0, all data_*d to 8'h00, all valid_*d to 0, frame_done to 0, idle_out to 0, and the idle-frame counter to 0.
REQ-021 While reset=1, the block SHALL ignore data_000 and valid_000.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; the first post-reset frame SHALL start at slot 0.

Configuration
REQ-023 With macro DEMUX_IDLE_EN defined, a 2-bit saturating counter SHALL count consecutive completed frames whose four valid bits are all 0.
REQ-024 With DEMUX_IDLE_EN defined, idle_out SHALL assert on the same edge that the second consecutive all-invalid frame is presented.
REQ-025 With DEMUX_IDLE_EN defined, idle_out SHALL deassert, and the counter SHALL clear, on the edge that presents any frame with at least one valid lane.
REQ-026 With DEMUX_IDLE_EN undefined, the block SHALL tie idle_out to 0 and contain no counter logic; all other behaviour is identical.

Verification
REQ-027 Release reset, then drive bytes 0xA0,0xA1,0xA2,0xA3 with valid=1 in slots 0..3 -> after the slot-3 edge, data_0d..data_3d=A0,A1,A2,A3, valid_*d=1, frame_done=1 for one cycle; outputs hold for 4 cycles.
REQ-028 Drive slots 0..3 as (0x11,v=1),(0x22,v=0),(0x33,v=1),(0x44,v=0) -> data_*d=11,00,33,00 and valid_*d=1,0,1,0.
REQ-029 Drive 3 back-to-back frames with distinct bytes -> each frame appears intact 4 cycles apart with exactly 3 frame_done pulses and no lane mixing.
REQ-030 Assert reset for 1 cycle after slot 1 of a frame, then send a new full frame 0x5x -> the partial frame never appears; the outputs show 0x50..0x53 at the first update after reset.
REQ-031 With DEMUX_IDLE_EN defined, send 3 all-invalid frames and then one valid frame -> idle_out rises with the 2nd frame, stays high through the 3rd, and falls with the valid frame; without the macro, idle_out=0 throughout.
